// File: rtl/ppm_slot_transmitter_if.sv
// Byte handshake between a data source and the PPM slot transmitter.
// The source drives data/valid; the transmitter answers with ready.
interface ppm_slot_transmitter_if;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic       tx_data_ready;

    modport master (
        output tx_data,
        output tx_data_valid,
        input  tx_data_ready
    );

    modport slave (
        input  tx_data,
        input  tx_data_valid,
        output tx_data_ready
    );
endinterface

// File: rtl/ppm_slot_transmitter.sv
// Slot-based PPM optical transmitter: frames bytes behind a sync word, one pulse
// per symbol in one of 2^PPM_BITS slots, guard slots after each symbol, gap after each frame.
module ppm_slot_transmitter #(
    parameter int unsigned SLOT_CYCLES  = 50,
    parameter int unsigned PULSE_CYCLES = 10,
    parameter int unsigned PPM_BITS     = 2,
    parameter int unsigned GUARD_SLOTS  = 1,
    parameter logic [7:0]  SYNC_WORD    = 8'hE4,
    parameter int unsigned FRAME_BYTES  = 32,
    parameter int unsigned GAP_SLOTS    = 10
) (
    input  logic                         CLOCK_50,
    input  logic                         reset_n,
    ppm_slot_transmitter_if.slave        tx,
    output logic                         ppm_out,
    output logic                         slot_strobe,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         underrun
);

    localparam int unsigned SPS       = (1 << PPM_BITS) + GUARD_SLOTS;
    localparam int unsigned SYMS      = 8 / PPM_BITS;
    localparam int unsigned SLOT_SPAN = (SPS > GAP_SLOTS) ? SPS : GAP_SLOTS;
    localparam int unsigned CYC_W     = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int unsigned SLOT_W    = (SLOT_SPAN > 1) ? $clog2(SLOT_SPAN) : 1;
    localparam int unsigned SYM_W     = (SYMS > 1) ? $clog2(SYMS) : 1;
    localparam int unsigned BYTE_W    = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SYNC = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [1:0]          state,     state_nx;
    logic [CYC_W-1:0]    cyc_cnt,   cyc_nx;
    logic [SLOT_W-1:0]   slot_idx,  slot_nx;
    logic [SYM_W-1:0]    sym_idx,   sym_nx;
    logic [BYTE_W-1:0]   byte_cnt,  byte_nx;
    logic [7:0]          shift_reg, shift_nx;
    logic [7:0]          hold_data, hold_data_nx;
    logic                hold_full, hold_full_nx;
    logic                ppm_nx, slot_strobe_nx, busy_nx, frame_done_nx, underrun_nx;

    logic                cyc_last, slot_last, sym_last, gap_last;
    logic                sym_end, byte_end;
    logic [PPM_BITS-1:0] symbol;

    assign tx.tx_data_ready = ~hold_full;

    assign cyc_last  = (cyc_cnt  == CYC_W'(SLOT_CYCLES - 1));
    assign slot_last = (slot_idx == SLOT_W'(SPS - 1));
    assign sym_last  = (sym_idx  == SYM_W'(SYMS - 1));
    assign gap_last  = (slot_idx == SLOT_W'(GAP_SLOTS - 1));
    assign sym_end   = cyc_last & slot_last;
    assign byte_end  = sym_end & sym_last;
    assign symbol    = shift_reg[7 -: PPM_BITS];

    // State register and all datapath registers
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            cyc_cnt     <= '0;
            slot_idx    <= '0;
            sym_idx     <= '0;
            byte_cnt    <= '0;
            shift_reg   <= '0;
            hold_data   <= '0;
            hold_full   <= 1'b0;
            ppm_out     <= 1'b0;
            slot_strobe <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            state       <= state_nx;
            cyc_cnt     <= cyc_nx;
            slot_idx    <= slot_nx;
            sym_idx     <= sym_nx;
            byte_cnt    <= byte_nx;
            shift_reg   <= shift_nx;
            hold_data   <= hold_data_nx;
            hold_full   <= hold_full_nx;
            ppm_out     <= ppm_nx;
            slot_strobe <= slot_strobe_nx;
            busy        <= busy_nx;
            frame_done  <= frame_done_nx;
            underrun    <= underrun_nx;
        end
    end

    // Next-state, counter chain and output decode
    always_comb begin
        state_nx      = state;
        cyc_nx        = cyc_cnt;
        slot_nx       = slot_idx;
        sym_nx        = sym_idx;
        byte_nx       = byte_cnt;
        shift_nx      = shift_reg;
        hold_data_nx  = hold_data;
        hold_full_nx  = hold_full;
        frame_done_nx = 1'b0;
        underrun_nx   = 1'b0;

        // Capture and load never coincide: ready is low whenever a load is possible
        if (tx.tx_data_valid && !hold_full) begin
            hold_data_nx = tx.tx_data;
            hold_full_nx = 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (hold_full) begin
                    state_nx = S_SYNC;
                    shift_nx = SYNC_WORD;
                    cyc_nx   = '0;
                    slot_nx  = '0;
                    sym_nx   = '0;
                    byte_nx  = '0;
                end
            end

            S_SYNC, S_DATA: begin
                cyc_nx = cyc_last ? '0 : cyc_cnt + 1'b1;
                if (cyc_last) begin
                    slot_nx = slot_last ? '0 : slot_idx + 1'b1;
                end
                if (sym_end) begin
                    shift_nx = shift_reg << PPM_BITS;
                    sym_nx   = sym_last ? '0 : sym_idx + 1'b1;
                end
                if (byte_end) begin
                    if (state == S_SYNC) begin
                        shift_nx     = hold_data;
                        hold_full_nx = 1'b0;
                        byte_nx      = '0;
                        state_nx     = S_DATA;
                    end else if (byte_cnt == BYTE_W'(FRAME_BYTES - 1)) begin
                        byte_nx = '0;
                        if (GAP_SLOTS == 0) begin
                            frame_done_nx = 1'b1;
                            state_nx      = S_IDLE;
                        end else begin
                            state_nx = S_GAP;
                        end
                    end else if (hold_full) begin
                        shift_nx     = hold_data;
                        hold_full_nx = 1'b0;
                        byte_nx      = byte_cnt + 1'b1;
                    end else begin
                        underrun_nx = 1'b1;
                        byte_nx     = '0;
                        state_nx    = S_IDLE;
                    end
                end
            end

            S_GAP: begin
                cyc_nx = cyc_last ? '0 : cyc_cnt + 1'b1;
                if (cyc_last) begin
                    if (gap_last) begin
                        slot_nx       = '0;
                        frame_done_nx = 1'b1;
                        state_nx      = S_IDLE;
                    end else begin
                        slot_nx = slot_idx + 1'b1;
                    end
                end
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Pulse is decoded from the current slot position, so it trails slot_strobe by one cycle
    assign ppm_nx = ((state == S_SYNC) || (state == S_DATA)) &&
                    (slot_idx == SLOT_W'(symbol)) &&
                    (cyc_cnt < CYC_W'(PULSE_CYCLES));

    assign slot_strobe_nx = (state_nx != S_IDLE) && (cyc_nx == '0);
    assign busy_nx        = (state_nx != S_IDLE);

endmodule

// File: doc/ppm_slot_transmitter.md
Name: ppm_slot_transmitter

Overview:
- Optical-link transmitter. Takes bytes over a valid/ready handshake and frames them behind a sync word.
- Each symbol of PPM_BITS bits becomes one pulse in one of 2^PPM_BITS slots, followed by GUARD_SLOTS empty slots. Defaults give 4 data slots + 1 guard = 5 slots per symbol.
- Drives the laser/LED modulator pin. It is the transmit-side counterpart of the photon-detect, slot-synchronisation and byte-recovery chain, and shares its slot timing and sync word.

Parameters:
SLOT_CYCLES, 50, clock cycles per slot (1 us at 50 MHz); must be >= 2
PULSE_CYCLES, 10, cycles ppm_out is high at the start of the pulse slot; 1..SLOT_CYCLES-1
PPM_BITS, 2, bits per symbol; legal values 1, 2, 4
GUARD_SLOTS, 1, empty slots appended to every symbol
SYNC_WORD, 8'hE4, preamble byte, sent before data using the same symbol encoding
FRAME_BYTES, 32, data bytes per frame
GAP_SLOTS, 10, empty slots after every frame, before the next sync

Ports:
CLOCK_50  input  1  system clock
reset_n  input  1  reset; synchronous, active-low
tx_data  input  8  data byte
tx_data_valid  input  1  tx_data valid
tx_data_ready  output  1  block can accept a byte this cycle
ppm_out  output  1  registered PPM pulse to the optical driver
slot_strobe  output  1  one-cycle pulse on cycle 0 of every slot while not IDLE
busy  output  1  high in every state except IDLE
frame_done  output  1  one-cycle pulse when GAP completes
underrun  output  1  one-cycle pulse when a frame is aborted for lack of data

Behaviour:
- Reset (reset_n low at a CLOCK_50 edge): state IDLE, all counters 0, holding register empty. All outputs 0 except tx_data_ready, which is 1 once out of reset. Reset mid-frame truncates the pulse immediately (ppm_out 0 after that edge); the held byte is discarded.
- Holding register: 8 bits plus hold_full flag.
  - tx_data_ready = ~hold_full.
  - Byte is captured on an edge where valid && ready.
  - hold_full clears when the shift register loads from it.
  - A capture and a load on the same edge is impossible, because ready is low while full.
- Timing counters:
  - cyc_cnt runs 0..SLOT_CYCLES-1.
  - slot_idx runs 0..SPS-1, where SPS = 2^PPM_BITS + GUARD_SLOTS.
  - sym_idx runs 0..8/PPM_BITS-1.
  - byte_cnt runs 0..FRAME_BYTES-1.
  - All counters wrap to 0 and carry into the next counter.
- Symbol value is shift_reg[7:8-PPM_BITS], MSB first. The register shifts left by PPM_BITS at the end of each symbol.
- ppm_out (registered) = 1 when state is SYNC or DATA, slot_idx == symbol, and cyc_cnt < PULSE_CYCLES. Guard slots never pulse.
- FSM:
  - IDLE: when hold_full, load shift_reg <= SYNC_WORD, zero all counters, go to SYNC. The held byte is not consumed.
  - SYNC: after the last cycle of the last symbol, load shift_reg from the holding register (clear hold_full), byte_cnt <= 0, go to DATA. hold_full is always 1 here.
  - DATA: at each byte boundary:
    - If byte_cnt == FRAME_BYTES-1, go to GAP.
    - Else if hold_full, load the next byte and increment byte_cnt.
    - Else pulse underrun, go to IDLE, no pulse emitted.
  - GAP: GAP_SLOTS empty slots. On the last cycle, pulse frame_done and go to IDLE. If hold_full at that point, the next frame's SYNC starts one cycle later through IDLE.
- Latency: for a byte accepted at edge k in IDLE, state becomes SYNC at edge k+1 and the first slot cycle 0 is the cycle after k+1.
  - slot_strobe is high that cycle.
  - ppm_out rises at edge k+2 if the first sync symbol is 0, otherwise at the start of the corresponding slot.
- tx_data_valid with ready low: the byte is held off and no data is lost. The source must hold tx_data stable until ready.

Test Plan:
(Bench parameters: SLOT_CYCLES=4, PULSE_CYCLES=2, FRAME_BYTES=2, GAP_SLOTS=5; symbol = 20 cycles, byte = 80 cycles.)
1. Reset, then idle 50 cycles -> ppm_out, busy, slot_strobe all 0; tx_data_ready=1.
2. Bytes 8'h1B, 8'hC6 offered back-to-back -> sync pulses in slots 3,2,1,0, then data slots 0,1,2,3 and 3,0,1,2. Each pulse is 2 cycles at slot start. frame_done fires 240+20 cycles after SYNC entry; underrun never pulses.
3. Only 8'h1B supplied -> after its 4 symbols, underrun pulses once; return to IDLE with ppm_out 0 and no further pulses.
4. tx_data_valid held high continuously for 4 bytes -> two consecutive frames with exactly 5 empty slots plus 1 IDLE cycle between them. Each byte is accepted exactly once (ready/valid scoreboard).
5. reset_n low for 1 cycle mid-pulse in DATA -> ppm_out 0 next cycle, state IDLE, held byte lost, tx_data_ready=1.
6. PPM_BITS=4, GUARD_SLOTS=1, byte 8'hF0 -> 17 slots per symbol; pulses in slots 15 then 0.
